lfsr_range_gen: RTL
===================

// Module: lfsr_range_gen
// PURPOSE
//  Parametrised pseudo-random range generator. A 16-bit Galois LFSR produces one candidate per cycle;
//  rejection sampling keeps candidates inside [LO,HI] that match the selected parity mode.
//  Accepted values are handed out over a valid/ready port. Serves as the stimulus source for
//  sequential-circuit benches in place of $random-based generators.
// PARAMETERS
//  WIDTH     7        output/candidate width; WIDTH <= 16
//  LO        34       inclusive lower bound; LO <= HI
//  HI        65       inclusive upper bound; HI <= 2**WIDTH-1
//  SEED      16'hACE1 LFSR reset value; 0 is replaced by 16'hACE1
//  MAX_TRIES 64       consecutive rejects before timeout; >= 2
// PORTS
//  clk        in  1     clock, all logic on posedge
//  rst        in  1     synchronous, active-high reset
//  en         in  1     1 = generate values
//  mode       in  2     00 any, 01 odd only, 10 even only, 11 treated as 00
//  seed_load  in  1     1-cycle pulse: load seed_in into LFSR
//  seed_in    in  16    seed value; 0 is replaced by 16'hACE1
//  data       out WIDTH accepted value, stable while out_valid=1
//  out_valid  out 1     data holds an untaken value
//  out_ready  in  1     consumer accepts data when out_valid & out_ready
//  err        out 1     sticky: MAX_TRIES consecutive rejects
//  reject_cnt out 16    saturating count of rejected candidates (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE, lfsr=SEED (or 16'hACE1), data=0, out_valid=0, err=0, reject_cnt=0, tries=0.
//  LFSR: Galois, right shift, taps 16'hB400; steps only in state GEN; never reaches 0.
//  Candidate c = lfsr[WIDTH-1:0] (pre-step value). Accept iff LO<=c<=HI and parity matches mode.
//  Priority: rst > seed_load > FSM. seed_load loads LFSR; clears out_valid, err, tries;
//   forces IDLE. Pending data is dropped.
//  FSM:
//   IDLE: en=1 & err=0 -> GEN. Otherwise stay. LFSR frozen.
//   GEN : en=0 -> IDLE without stepping. Else evaluate c and step LFSR:
//     accept -> data<=c, out_valid<=1, tries<=0, -> HOLD.
//     reject -> tries++, reject_cnt++. If tries reaches MAX_TRIES-1 before the increment:
//       err<=1, tries<=0, -> IDLE.
//   HOLD: data and out_valid stable. LFSR frozen. On out_valid&out_ready: out_valid<=0,
//     -> GEN if en else IDLE. en=0 never drops an untaken value.
//  Latency: first data is registered 1 cycle after entry into GEN on an accepted candidate.
//   Maximum throughput is 1 value per 2 cycles.
//  mode is sampled every GEN cycle; a change applies to the next candidate.
//  Bounds and parity are checked at full WIDTH, unsigned. No arithmetic wrap.
//  Empty range (e.g. LO=HI=34, mode odd) always ends in err. err clears only on rst or seed_load.
// CONFIGURATION
//  LFSR_RANGE_STATS_EN defined:
//   reject_cnt counts every rejected candidate and saturates at 16'hFFFF.
//   Cleared by rst and seed_load.
//  Not defined:
//   reject_cnt is tied to 0 and no counter is synthesised.
//   All other behaviour is identical.
// TESTING
//  T1 Defaults, mode=01, en=1, out_ready=1, 2000 cycles -> every handshaken data is odd,
//   in [34,65]; err=0.
//  T2 mode=10 same run -> all data even in [34,65]. Switch to 00 mid-run -> both parities seen;
//   no value outside range.
//  T3 out_ready=0 for 10 cycles after out_valid rises -> data/out_valid stable.
//   Raise ready -> one transfer; out_valid low the next cycle.
//  T4 LO=HI=34, mode=01 -> err=1 after exactly 64 GEN cycles; state IDLE; out_valid never 1.
//   seed_load clears err.
//  T5 seed_load with 16'h1234, capture 20 values. Repeat seed_load 16'h1234 -> identical sequence.
//   seed_in=0 gives the same sequence as seed 16'hACE1.
//  T6 rst in HOLD -> next cycle out_valid=0, data=0, err=0. With LFSR_RANGE_STATS_EN defined,
//   reject_cnt equals the bench-modelled reject count, then reads 0 after rst.

Source files
------------

// File: rtl/lfsr_range_gen.sv
// Pseudo-random range generator: a 16-bit Galois LFSR feeds rejection sampling against [LO,HI] and a parity mode.
// Optional build macro LFSR_RANGE_STATS_EN enables the saturating reject counter; otherwise reject_cnt is tied to 0.
module lfsr_range_gen #(
  parameter int          WIDTH     = 7,
  parameter int          LO        = 34,
  parameter int          HI        = 65,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             seed_load,
  input  logic [15:0]      seed_in,
  output logic [WIDTH-1:0] data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic [15:0]      reject_cnt
);

  localparam logic [15:0]      TAPS      = 16'hB400;
  localparam logic [15:0]      SEED_SAFE = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [WIDTH-1:0] LO_W      = WIDTH'(LO);
  localparam logic [WIDTH-1:0] HI_W      = WIDTH'(HI);
  localparam int               TW        = $clog2(MAX_TRIES);
  localparam logic [TW-1:0]    TRY_LAST  = TW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_reg;
  logic [15:0]      lfsr_reg;
  logic [15:0]      lfsr_next;
  logic [15:0]      seed_safe_in;
  logic [WIDTH-1:0] data_reg;
  logic             out_valid_reg;
  logic             err_reg;
  logic [TW-1:0]    tries_reg;

  logic [WIDTH-1:0] cand;
  logic             in_range;
  logic             parity_ok;
  logic             accept;

  // Right-shifting Galois step: the bit shifted out is folded back in on the tap positions.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lfsr
      if (gi == 15) begin : g_top
        assign lfsr_next[gi] = TAPS[gi] & lfsr_reg[0];
      end else begin : g_mid
        assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (TAPS[gi] & lfsr_reg[0]);
      end
    end
  endgenerate

  // An all-zero seed would lock the LFSR, so it is swapped for the default pattern.
  assign seed_safe_in = (seed_in == 16'h0000) ? 16'hACE1 : seed_in;

  assign cand     = lfsr_reg[WIDTH-1:0];
  assign in_range = (cand >= LO_W) && (cand <= HI_W);

  always_comb begin
    parity_ok = 1'b1;
    case (mode)
      2'b01:   parity_ok = cand[0];
      2'b10:   parity_ok = ~cand[0];
      default: parity_ok = 1'b1;
    endcase
  end

  assign accept = in_range && parity_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      lfsr_reg      <= SEED_SAFE;
      data_reg      <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      tries_reg     <= '0;
    end else if (seed_load) begin
      // Reseeding restarts the stream: any untaken value is dropped.
      state_reg     <= IDLE;
      lfsr_reg      <= seed_safe_in;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      tries_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (en && !err_reg) begin
            state_reg <= GEN;
          end
        end
        GEN: begin
          if (!en) begin
            state_reg <= IDLE;
          end else begin
            lfsr_reg <= lfsr_next;
            if (accept) begin
              data_reg      <= cand;
              out_valid_reg <= 1'b1;
              tries_reg     <= '0;
              state_reg     <= HOLD;
            end else if (tries_reg == TRY_LAST) begin
              err_reg   <= 1'b1;
              tries_reg <= '0;
              state_reg <= IDLE;
            end else begin
              tries_reg <= tries_reg + 1'b1;
            end
          end
        end
        HOLD: begin
          // out_valid is always high here, so out_ready alone completes the handshake.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= en ? GEN : IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign data      = data_reg;
  assign out_valid = out_valid_reg;
  assign err       = err_reg;

`ifdef LFSR_RANGE_STATS_EN
  logic        reject_now;
  logic [15:0] reject_cnt_reg;

  assign reject_now = (state_reg == GEN) && en && !accept;

  always_ff @(posedge clk) begin
    if (rst || seed_load) begin
      reject_cnt_reg <= '0;
    end else if (reject_now && (reject_cnt_reg != 16'hFFFF)) begin
      reject_cnt_reg <= reject_cnt_reg + 16'd1;
    end
  end

  assign reject_cnt = reject_cnt_reg;
`else
  assign reject_cnt = '0;
`endif

endmodule
